// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the seq_scan_ctrl pattern-scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  localparam int          LEN_W_DEF = len_w(PAT_W_DEF);
  localparam logic [15:0] POS_SAT   = 16'hFFFF;

endpackage

// File: rtl/seq_match_core.sv
// Serial history register, fill counter and masked pattern compare with a registered match pulse.
module seq_match_core #(
  parameter int PAT_W = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             x,
  input  logic             ovl,
  input  logic [PAT_W-1:0] pat,
  input  logic [LW-1:0]    len,
  output logic             hit,
  output logic             y
);

  localparam logic [LW-1:0] FILL_MAX = LW'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LW-1:0]    fill;
  logic [LW-1:0]    fill_next;

  always_comb begin
    hist_next = {hist[PAT_W-2:0], x};
    fill_next = (fill == FILL_MAX) ? fill : fill + LW'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LW'(i) < len);
    end
    hit = shift && (fill_next >= len) && (((hist_next ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else begin
      y <= hit;
      if (shift) begin
        hist <= hist_next;
        // non-overlapping mode forces the next match to see len fresh bits
        fill <= (hit && !ovl) ? '0 : fill_next;
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Run-time-configurable serial pattern-scan controller (arm/scan/done sequencing, match counting).
// Optional MATCH_POS_EN adds first_pos: index of the last bit of the first match after arm.
//
// state | meaning
// IDLE  | waiting for start, config writable
// ARM   | one cycle: clear history, fill, match count
// SCAN  | accepting bits and detecting matches
// DONE  | target reached, config writable, x ignored
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pat,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_ovl,
  input  logic [CNT_W-1:0]           cfg_tgt,
  output logic                       cfg_err,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       x,
  input  logic                       x_vld,
  output logic                       x_rdy,
  output logic                       y,
`ifdef MATCH_POS_EN
  output logic [15:0]                first_pos,
`endif
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       done,
  output logic [1:0]                 state
);

  localparam int LW = len_w(PAT_W);
  localparam logic [LW-1:0] LEN_MAX = LW'(PAT_W);

  state_t           state_q;
  state_t           state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             arm_clr;
  logic             shift;
  logic             tgt_hit;

  assign state   = state_q;
  assign shift   = x_vld && x_rdy;
  assign cnt_inc = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
  assign tgt_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!abort && start) state_d = ARM;
      ARM:  state_d = abort ? IDLE : SCAN;
      SCAN: begin
        if (abort)        state_d = IDLE;
        else if (tgt_hit) state_d = DONE;
      end
      DONE: begin
        if (abort)      state_d = IDLE;
        else if (start) state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_rdy   = (state_q == SCAN);
    done    = (state_q == DONE);
    arm_clr = (state_q == ARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= '0;
      len_q   <= LW'(1);
      ovl_q   <= 1'b1;
      tgt_q   <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we && (state_q == IDLE || state_q == DONE)) begin
        if (cfg_len == '0 || cfg_len > LEN_MAX) begin
          cfg_err <= 1'b1;
        end else begin
          pat_q <= cfg_pat;
          len_q <= cfg_len;
          ovl_q <= cfg_ovl;
          tgt_q <= cfg_tgt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       match_cnt <= '0;
    else if (arm_clr) match_cnt <= '0;
    else if (hit)     match_cnt <= cnt_inc;
  end

`ifdef MATCH_POS_EN
  logic [15:0] pos_cnt;
  logic        seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_cnt   <= '0;
      first_pos <= POS_SAT;
      seen_q    <= 1'b0;
    end else if (arm_clr) begin
      pos_cnt   <= '0;
      first_pos <= POS_SAT;
      seen_q    <= 1'b0;
    end else if (shift) begin
      if (pos_cnt != POS_SAT) pos_cnt <= pos_cnt + 16'd1;
      if (hit && !seen_q) begin
        first_pos <= pos_cnt;
        seen_q    <= 1'b1;
      end
    end
  end
`endif

  seq_match_core #(
    .PAT_W (PAT_W),
    .LW    (LW)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (arm_clr),
    .shift (shift),
    .x     (x),
    .ovl   (ovl_q),
    .pat   (pat_q),
    .len   (len_q),
    .hit   (hit),
    .y     (y)
  );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl (first_pos checked when MATCH_POS_EN is defined).
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_ovl = 1'b0;
  logic [7:0] cfg_tgt = '0;
  logic       cfg_err;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x = 1'b0;
  logic       x_vld = 1'b0;
  logic       x_rdy;
  logic       y;
  logic [7:0] match_cnt;
  logic       done;
  logic [1:0] state;
`ifdef MATCH_POS_EN
  logic [15:0] first_pos;
`endif

  int total = 0;
  int bad = 0;

  seq_scan_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_ovl   (cfg_ovl),
    .cfg_tgt   (cfg_tgt),
    .cfg_err   (cfg_err),
    .start     (start),
    .abort     (abort),
    .x         (x),
    .x_vld     (x_vld),
    .x_rdy     (x_rdy),
    .y         (y),
`ifdef MATCH_POS_EN
    .first_pos (first_pos),
`endif
    .match_cnt (match_cnt),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_tgt = t;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({state, y, done, cfg_err, x_rdy, match_cnt} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got state=%0d y=%b done=%b err=%b rdy=%b cnt=%0d, want all 0",
               state, y, done, cfg_err, x_rdy, match_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL reset_idle: got %0d want 0", state); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] ey   = 7'b0001001;
    cfg(8'b1101, 4'd4, 1'b1, 8'd0);
    arm();
    total++;
    if (state !== 2'd2 || x_rdy !== 1'b1) begin
      bad++; $display("FAIL ovl_scan: got state=%0d rdy=%b want 2/1", state, x_rdy);
    end
    for (int i = 6; i >= 0; i--) begin
      x = bits[i]; x_vld = 1'b1;
      step();
      total++;
      if (y !== ey[i]) begin bad++; $display("FAIL ovl_y bit%0d: got %b want %b", 7-i, y, ey[i]); end
    end
    x_vld = 1'b0;
    total++;
    if (match_cnt !== 8'd2) begin bad++; $display("FAIL ovl_cnt: got %0d want 2", match_cnt); end
`ifdef MATCH_POS_EN
    total++;
    if (first_pos !== 16'd3) begin bad++; $display("FAIL ovl_pos: got %0d want 3", first_pos); end
`endif
    do_abort();
    total++;
    if (state !== 2'd0 || match_cnt !== 8'd2) begin
      bad++; $display("FAIL abort_keep: got state=%0d cnt=%0d want 0/2", state, match_cnt);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] ey   = 7'b0001000;
    cfg(8'b1101, 4'd4, 1'b0, 8'd0);
    arm();
    for (int i = 6; i >= 0; i--) begin
      x = bits[i]; x_vld = 1'b1;
      step();
      total++;
      if (y !== ey[i]) begin bad++; $display("FAIL novl_y bit%0d: got %b want %b", 7-i, y, ey[i]); end
    end
    x_vld = 1'b0;
    total++;
    if (match_cnt !== 8'd1) begin bad++; $display("FAIL novl_cnt: got %0d want 1", match_cnt); end
    do_abort();
  endtask

  task automatic test_target();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] ey   = 7'b0001001;
    cfg(8'b1101, 4'd4, 1'b1, 8'd2);
    arm();
    for (int i = 6; i >= 0; i--) begin
      x = bits[i]; x_vld = 1'b1;
      step();
      total++;
      if (y !== ey[i]) begin bad++; $display("FAIL tgt_y bit%0d: got %b want %b", 7-i, y, ey[i]); end
    end
    total++;
    if (state !== 2'd3 || done !== 1'b1 || x_rdy !== 1'b0 || match_cnt !== 8'd2) begin
      bad++; $display("FAIL tgt_done: got state=%0d done=%b rdy=%b cnt=%0d want 3/1/0/2",
                      state, done, x_rdy, match_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      x = (i % 2 == 0);
      step();
      total++;
      if (y !== 1'b0 || match_cnt !== 8'd2 || state !== 2'd3) begin
        bad++; $display("FAIL tgt_ignore: got y=%b cnt=%0d state=%0d want 0/2/3", y, match_cnt, state);
      end
    end
    x_vld = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (state !== 2'd1 || done !== 1'b0) begin
      bad++; $display("FAIL tgt_rearm: got state=%0d done=%b want 1/0", state, done);
    end
    step();
    total++;
    if (state !== 2'd2 || match_cnt !== 8'd0) begin
      bad++; $display("FAIL tgt_clear: got state=%0d cnt=%0d want 2/0", state, match_cnt);
    end
    do_abort();
  endtask

  task automatic test_cfg();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] ey   = 7'b0001001;
    cfg(8'b1101, 4'd4, 1'b1, 8'd0);
    cfg(8'h00, 4'd0, 1'b0, 8'd1);
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_len0: got %b want 1", cfg_err); end
    step();
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_pulse: got %b want 0", cfg_err); end
    cfg(8'h00, 4'd9, 1'b0, 8'd1);
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_len9: got %b want 1", cfg_err); end
    arm();
    cfg(8'h00, 4'd1, 1'b0, 8'd1);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_scan: got %b want 0", cfg_err); end
    for (int i = 6; i >= 0; i--) begin
      x = bits[i]; x_vld = 1'b1;
      step();
      total++;
      if (y !== ey[i]) begin bad++; $display("FAIL cfg_keep_y bit%0d: got %b want %b", 7-i, y, ey[i]); end
    end
    x_vld = 1'b0;
    total++;
    if (state !== 2'd2 || match_cnt !== 8'd2) begin
      bad++; $display("FAIL cfg_keep_cnt: got state=%0d cnt=%0d want 2/2", state, match_cnt);
    end
    do_abort();
  endtask

  task automatic test_reset_mid();
    logic [2:0] bits = 3'b110;
    cfg(8'b1101, 4'd4, 1'b1, 8'd0);
    arm();
    for (int i = 2; i >= 0; i--) begin
      x = bits[i]; x_vld = 1'b1;
      step();
    end
    x_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({state, y, done, cfg_err, x_rdy, match_cnt} !== 13'd0) begin
      bad++; $display("FAIL mid_reset: got state=%0d y=%b done=%b rdy=%b cnt=%0d want all 0",
                      state, y, done, x_rdy, match_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    x = 1'b1; x_vld = 1'b1;
    step();
    step();
    total++;
    if (state !== 2'd0 || y !== 1'b0) begin
      bad++; $display("FAIL post_reset: got state=%0d y=%b want 0/0", state, y);
    end
    x_vld = 1'b0;
    // default config after reset is pat=0 len=1: a single 0 bit matches
    arm();
    x = 1'b0; x_vld = 1'b1;
    step();
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL default_cfg_0: got %b want 1", y); end
    x = 1'b1;
    step();
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL default_cfg_1: got %b want 0", y); end
    x_vld = 1'b0;
    do_abort();
  endtask

  task automatic test_start_abort();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL start_abort: got %0d want 0", state); end
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL arm_abort: got %0d want 0", state); end
  endtask

  task automatic test_gaps();
    logic [7:0] vld = 8'b10100110;
    logic [7:0] xs  = 8'b10110010;
    logic [7:0] ey  = 8'b00000010;
    cfg(8'b1101, 4'd4, 1'b1, 8'd0);
    arm();
    for (int i = 7; i >= 0; i--) begin
      x = xs[i]; x_vld = vld[i];
      step();
      total++;
      if (y !== ey[i]) begin bad++; $display("FAIL gap_y cyc%0d: got %b want %b", 7-i, y, ey[i]); end
    end
    x_vld = 1'b0;
    total++;
    if (match_cnt !== 8'd1) begin bad++; $display("FAIL gap_cnt: got %0d want 1", match_cnt); end
`ifdef MATCH_POS_EN
    total++;
    if (first_pos !== 16'd3) begin bad++; $display("FAIL gap_pos: got %0d want 3", first_pos); end
`endif
    do_abort();
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_cfg();
    test_reset_mid();
    test_start_abort();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Run-time-configurable serial pattern-scan controller.
- Holds a programmable pattern (e.g. 1101) and its length, and sequences arm/scan/done phases over a valid-qualified serial bit stream.
- Emits a registered Moore-style match pulse and counts matches up to a target.
- Sits between a host/config side and a serial input, replacing hard-wired single-pattern detectors.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- CNT_W, 8, width of match counter and target.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_we  input  1  configuration write strobe.
- cfg_pat  input  PAT_W  pattern; bit 0 is the newest (last) bit of the sequence.
- cfg_len  input  $clog2(PAT_W+1)  pattern length, legal 1..PAT_W.
- cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_tgt  input  CNT_W  match target; 0 = unlimited.
- cfg_err  output  1  one-cycle pulse on an illegal cfg_len.
- start  input  1  arm request.
- abort  input  1  return to IDLE.
- x  input  1  serial data bit.
- x_vld  input  1  x is valid this cycle.
- x_rdy  output  1  bit accepted (high only in SCAN).
- y  output  1  match pulse (registered).
- match_cnt  output  CNT_W  matches since last arm.
- done  output  1  target reached.
- state  output  2  FSM state (IDLE=0, ARM=1, SCAN=2, DONE=3).

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; y=0, done=0, cfg_err=0, match_cnt=0, x_rdy=0.
  - History and fill cleared.
  - Config registers reset to pat=0, len=1, ovl=1, tgt=0.
- Config:
  - cfg_we is honoured only in IDLE or DONE; ignored in ARM/SCAN.
  - cfg_len of 0 or >PAT_W: all config left unchanged, cfg_err pulses the next cycle.
- FSM transitions:
  - IDLE -start-> ARM.
  - ARM always -> SCAN after 1 cycle. ARM clears history, fill and match_cnt.
  - SCAN -abort-> IDLE.
  - SCAN -(tgt!=0 and match_cnt reaches tgt)-> DONE.
  - DONE -start-> ARM; DONE -abort-> IDLE.
  - IDLE and DONE ignore x.
- Priority: abort beats start in the same cycle. Abort in ARM -> IDLE. match_cnt is retained on abort.
- Bit acceptance: x_rdy = (state==SCAN). A bit is accepted when x_vld && x_rdy.
  - On accept: hist <= {hist[PAT_W-2:0], x}; fill saturates at PAT_W.
- Match condition: on an accepted bit, fill_next >= len and hist_next[len-1:0] == pat[len-1:0].
- Match effects:
  - y=1 for exactly one cycle, one cycle after the accepting edge (Moore, registered).
  - match_cnt increments in the same cycle y rises and saturates at all-ones.
  - If match_cnt+1 == tgt (tgt!=0): state -> DONE on that same edge, with done=1 and x_rdy=0 from then on.
- Overlap handling:
  - ovl=1: history is kept, so 1101101 with pat 1101 gives 2 matches.
  - ovl=0: fill is cleared on a match, so the next match needs len fresh bits.
- done is held high while in DONE and cleared on leaving DONE.
- No accepted bit -> no shift and no match. Gaps in x_vld are transparent.

Optional Feature:
- MATCH_POS_EN defined:
  - Adds output first_pos (16 bits) plus an internal accepted-bit index counter. The counter is cleared in ARM, increments per accepted bit and saturates at 0xFFFF.
  - first_pos latches the index (0-based) of the last bit of the first match after arm. It holds 0xFFFF if no match has occurred.
- MATCH_POS_EN undefined: the port, counter and latch are absent.

Decomposition:
- Package seq_scan_pkg: state enum (IDLE/ARM/SCAN/DONE), length-width constant, saturated-index constant 0xFFFF.
- One sub-module, seq_match_core: history shift register, fill counter, masked compare and registered y. Controlled by clr/shift/ovl from the FSM.

Test Plan:
- Config pat=4'b1101, len=4, ovl=1, tgt=0; start; x_vld=1 stream 1,1,0,1,1,0,1 -> y pulses after bit 4 and bit 7; match_cnt=2.
- Same stream with ovl=0 -> a single y pulse after bit 4; match_cnt=1.
- ovl=1, tgt=2, same stream -> done=1 and state=3 on the bit-7 edge; later x ignored (x_rdy=0); start -> ARM, match_cnt=0.
- cfg_we with len=0, and len=9 for PAT_W=8 -> cfg_err pulse, config unchanged; cfg_we during SCAN -> ignored, detection continues with the old pattern.
- rst_n low after 1,1,0 in SCAN -> all outputs 0 immediately; after release, state=IDLE and no y on a following 1.
- start and abort together in IDLE -> stays IDLE. x_vld gaps inside 1,1,0,1 -> single match, y delayed only by the gaps.
